// File: rtl/cont_dezena_disp.sv
// Tens-digit counter fed by the mod-10 units counter, with a carry on the tens wrap
// and a two-digit time-multiplexed 7-segment driver.
module cont_dezena_disp #(
    parameter int DEZ_MAX    = 5,
    parameter int SCAN_DIV   = 4,
    parameter int BLANK_ZERO = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unid,
    input  logic       clr,
    output logic [3:0] dez,
    output logic       carry,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       err
);

    localparam int            PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [3:0]    DMAX     = 4'(DEZ_MAX);
    localparam logic          BLANK    = (BLANK_ZERO != 0);

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h00;
        endcase
    endfunction

    logic [3:0]    unid_q, unid_d;
    logic [3:0]    dez_q, dez_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          sel_q, sel_d;
    logic [6:0]    seg_q, seg_d;
    logic [1:0]    an_q, an_d;
    logic          tick;

    always_comb begin
        unid_d = unid;
        // Only a genuine 9->0 wrap counts; an upstream reset to 0 or an illegal code does not.
        tick    = (unid_q == 4'd9) && (unid == 4'd0);
        dez_d   = dez_q;
        carry_d = 1'b0;
        if (clr) begin
            dez_d = 4'd0;
        end else if (tick) begin
            if (dez_q == DMAX) begin
                dez_d   = 4'd0;
                carry_d = 1'b1;
            end else begin
                dez_d = dez_q + 4'd1;
            end
        end

        err_d = err_q | (unid > 4'd9);

        if (pre_q == PRE_LAST) begin
            pre_d = '0;
            sel_d = ~sel_q;
        end else begin
            pre_d = pre_q + 1'b1;
            sel_d = sel_q;
        end

        if (sel_q) begin
            an_d  = 2'b10;
            seg_d = (BLANK && (dez_q == 4'd0)) ? 7'h00 : decode(dez_q);
        end else begin
            an_d  = 2'b01;
            seg_d = decode(unid_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unid_q  <= 4'd0;
            dez_q   <= 4'd0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            pre_q   <= '0;
            sel_q   <= 1'b0;
            seg_q   <= 7'h00;
            an_q    <= 2'b00;
        end else begin
            unid_q  <= unid_d;
            dez_q   <= dez_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            pre_q   <= pre_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign dez   = dez_q;
    assign carry = carry_q;
    assign err   = err_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_cont_dezena_disp.sv
// Directed bench for cont_dezena_disp with DEZ_MAX=5, SCAN_DIV=4, BLANK_ZERO=1.
module tb_cont_dezena_disp;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] unid;
    logic       clr;
    logic [3:0] dez;
    logic       carry;
    logic [6:0] seg;
    logic [1:0] an;
    logic       err;

    int n_vec = 0;
    int n_err = 0;
    int edges = 0;
    logic [1:0] exp_an;

    cont_dezena_disp #(
        .DEZ_MAX   (5),
        .SCAN_DIV  (SD),
        .BLANK_ZERO(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .unid (unid),
        .clr  (clr),
        .dez  (dez),
        .carry(carry),
        .seg  (seg),
        .an   (an),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock edge; the select pattern since the last reset release is checked every edge.
    task automatic step();
        @(posedge clk);
        #1;
        edges++;
        exp_an = ((((edges - 1) / SD) % 2) == 0) ? 2'b01 : 2'b10;
        chk("an_scan", {6'd0, an}, {6'd0, exp_an});
    endtask

    task automatic drive(input logic [3:0] u);
        unid = u;
        step();
    endtask

    // Units run 1..9 then 0, producing exactly one wrap.
    task automatic one_wrap();
        for (int u = 1; u <= 9; u++) drive(4'(u));
        drive(4'd0);
    endtask

    initial begin
        rst  = 1'b1;
        unid = 4'd0;
        clr  = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst0_dez", {4'd0, dez}, 8'h00);
        chk("rst0_carry", {7'd0, carry}, 8'h00);
        chk("rst0_err", {7'd0, err}, 8'h00);
        chk("rst0_seg", {1'b0, seg}, 8'h00);
        chk("rst0_an", {6'd0, an}, 8'h00);
        #5 rst = 1'b1;
        edges = 0;

        // First edge: units slot showing the reset units value.
        drive(4'd0);
        chk("first_seg", {1'b0, seg}, 8'h3F);

        for (int c = 1; c <= 3; c++) one_wrap();
        chk("pre_rst_dez", {4'd0, dez}, 8'h03);
        for (int u = 1; u <= 9; u++) drive(4'(u));
        chk("hold9_dez", {4'd0, dez}, 8'h03);

        // Asynchronous reset between edges, with a 9 left in the units history.
        unid = 4'd0;
        #3 rst = 1'b0;
        #1;
        chk("arst_dez", {4'd0, dez}, 8'h00);
        chk("arst_carry", {7'd0, carry}, 8'h00);
        chk("arst_an", {6'd0, an}, 8'h00);
        chk("arst_seg", {1'b0, seg}, 8'h00);
        chk("arst_err", {7'd0, err}, 8'h00);
        #2 rst = 1'b1;
        edges = 0;

        drive(4'd0);
        chk("stale9_dez", {4'd0, dez}, 8'h00);
        chk("stale9_carry", {7'd0, carry}, 8'h00);
        chk("post_rst_seg", {1'b0, seg}, 8'h3F);

        // Six wraps: dez 1,2,3,4,5,0 with one carry on the last.
        for (int c = 1; c <= 6; c++) begin
            for (int u = 1; u <= 9; u++) begin
                drive(4'(u));
                chk("cnt_carry_low", {7'd0, carry}, 8'h00);
            end
            drive(4'd0);
            chk("cnt_dez", {4'd0, dez}, 8'(c % 6));
            chk("cnt_carry", {7'd0, carry}, (c == 6) ? 8'h01 : 8'h00);
        end
        drive(4'd1);
        chk("carry_one_cycle", {7'd0, carry}, 8'h00);

        // 5->0 is not a wrap; 9->0 is.
        for (int u = 2; u <= 5; u++) drive(4'(u));
        drive(4'd0);
        chk("nowrap_dez", {4'd0, dez}, 8'h00);
        chk("nowrap_carry", {7'd0, carry}, 8'h00);
        one_wrap();
        chk("wrap_dez", {4'd0, dez}, 8'h01);

        // Align so the illegal code lands in the units slot on the following edge.
        for (int i = 0; i < 8; i++) begin
            if (((((edges + 1) / SD) % 2) == 0)) break;
            drive(4'd0);
        end
        drive(4'd12);
        chk("ill_err", {7'd0, err}, 8'h01);
        chk("ill_dez", {4'd0, dez}, 8'h01);
        drive(4'd0);
        chk("ill_an", {6'd0, an}, 8'h01);
        chk("ill_seg", {1'b0, seg}, 8'h00);
        chk("ill_notick_dez", {4'd0, dez}, 8'h01);
        for (int i = 0; i < 5; i++) drive(4'd0);
        chk("err_sticky", {7'd0, err}, 8'h01);

        // clr wins over a wrap at DEZ_MAX.
        for (int c = 0; c < 4; c++) one_wrap();
        chk("prio_pre_dez", {4'd0, dez}, 8'h05);
        for (int u = 1; u <= 9; u++) drive(4'(u));
        clr = 1'b1;
        drive(4'd0);
        clr = 1'b0;
        chk("prio_dez", {4'd0, dez}, 8'h00);
        chk("prio_carry", {7'd0, carry}, 8'h00);

        // Scan content with dez=3, unid=7.
        for (int c = 0; c < 3; c++) one_wrap();
        chk("scan_dez", {4'd0, dez}, 8'h03);
        drive(4'd7);
        for (int i = 0; i < 2 * SD * 2; i++) begin
            drive(4'd7);
            chk("scan_seg", {1'b0, seg}, (exp_an == 2'b01) ? 8'h07 : 8'h4F);
        end

        // Tens blanked while zero.
        clr = 1'b1;
        drive(4'd7);
        clr = 1'b0;
        drive(4'd7);
        for (int i = 0; i < 2 * SD; i++) begin
            drive(4'd7);
            chk("blank_seg", {1'b0, seg}, (exp_an == 2'b01) ? 8'h07 : 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cont_dezena_disp.md
# cont_dezena_disp

Tens-digit stage and two-digit display driver placed directly downstream of the mod-10 units counter. It watches the units count `cont[3:0]` for the 9→0 wrap and advances a tens digit that wraps at `DEZ_MAX`. It raises a carry pulse on the tens wrap. Both digits are time-multiplexed onto a shared 7-segment bus with a digit-select output.

## Interface
- `DEZ_MAX`, default 5: highest tens value; tens counts 0..DEZ_MAX, then wraps to 0.
- `SCAN_DIV`, default 4: clock cycles each digit stays selected; ≥1.
- `BLANK_ZERO`, default 1: 1 = tens digit blanked while 0.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `unid`, in, 4: units digit from the mod-10 counter; legal values 0–9.
- `clr`, in, 1: synchronous clear of the tens digit, active-high.
- `dez`, out, 4: tens digit, binary/BCD, 0..DEZ_MAX.
- `carry`, out, 1: one-cycle pulse when `dez` wraps DEZ_MAX→0.
- `seg`, out, 7: segments {g,f,e,d,c,b,a}, active-high.
- `an`, out, 2: one-hot digit select, active-high. `an[0]` is units; `an[1]` is tens.
- `err`, out, 1: sticky flag; `unid` > 9 was sampled.

## Operation
- Reset (`rst`=0, asynchronous): `dez`=0, `carry`=0, `err`=0, `seg`=7'h00, `an`=2'b00. Internal `unid_q`=0, scan select=0, prescaler=0.
- Every edge: `unid_q` ← `unid`.
- Wrap detect: `tick` = (`unid_q`==9) && (`unid`==0). Any other transition to 0 (upstream reset) does not tick.
- Tens update on `tick`:
  - `dez` ← (`dez`==DEZ_MAX) ? 0 : `dez`+1.
  - `carry` ← 1 only when wrapping; otherwise `carry` ← 0.
- `clr`=1 has priority over `tick`: `dez` ← 0, `carry` ← 0.
- `err` ← 1 whenever `unid` > 9 is sampled. Only `rst` clears it.
  - An illegal `unid` never produces `tick`.
  - An illegal `unid` is shown blank (segments 0).
- Scan:
  - Prescaler counts 0..SCAN_DIV-1.
  - At the terminal count, it returns to 0 and the select toggles.
- Display, registered each edge:
  - Select=0: `an` ← 2'b01, `seg` ← decode(`unid_q`).
  - Select=1: `an` ← 2'b10, `seg` ← decode(`dez`), or 7'h00 if BLANK_ZERO && `dez`==0.
- Decode (hex, gfedcba): 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F; others: 00.
- Widths: `dez` is 4 bits; DEZ_MAX ≤ 9. Prescaler width is $clog2(SCAN_DIV), minimum 1.

## Timing
- `tick` latency: `unid` becomes 0 before edge k with `unid_q`=9. At edge k, `dez` increments and `unid_q` becomes 0.
- `carry` is registered. It is high for exactly the one cycle following edge k, in which `dez` already reads 0.
- Back-to-back wraps: each 9→0 transition produces exactly one increment, with no minimum spacing.
- `seg`/`an` lag the select and digit values by one edge.
- Digit-select period is 2·SCAN_DIV cycles; each digit gets SCAN_DIV cycles.
- First scan edge after reset: `an`=01 with units data.
- `rst` asserted mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.
- On `rst` release: `unid_q`=0, so a stale 9 cannot cause a spurious tick.
- `clr` and `tick` on the same edge: `dez`=0, `carry`=0.

## Test plan
- Reset: run to `dez`=3, then pulse `rst`=0 between edges → `dez`=0, `carry`=0, `an`=00, `seg`=00 with no clock edge. `err` stays cleared.
- Counting, DEZ_MAX=5: drive `unid` 0..9 repeatedly for 6 cycles of 10 → `dez` goes 1,2,3,4,5,0. Exactly one `carry` pulse, in the cycle `dez`=0.
- Non-wrap zero: `unid` 5→0 → `dez` unchanged, no `carry`. Then `unid` 9→0 → `dez`+1.
- Illegal input: `unid`=12 for one cycle → `err`=1 and stays 1. `dez` unchanged. Units slot shows `seg`=00.
- Priority: `clr`=1 on the edge where `unid` goes 9→0 with `dez`=5 → `dez`=0, `carry`=0.
- Scan, SCAN_DIV=4, `dez`=3, `unid`=7 → `an` alternates 01/10 every 4 cycles. `seg`=07 with `an`=01 and `seg`=4F with `an`=10. With `dez`=0 and BLANK_ZERO=1, `seg`=00 while `an`=10.
